// File: rtl/enc_dec.sv
// enc_dec: registered one-hot encode/decode loop-back.
// Stage 1 priority-encodes In (MSB wins) into a binary code plus status flags;
// stage 2 decodes the code back to a one-hot vector. All outputs share stage 2,
// so Out, Code, Valid and Multi are aligned two rising edges after In.
module enc_dec #(
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  In,
  output logic [WIDTH-1:0]  Out,
  output logic [CODE_W-1:0] Code,
  output logic              Valid,
  output logic              Multi
);

  // Stage 1 registers (encoder results)
  logic [CODE_W-1:0] code1_q, code1_d;
  logic              valid1_q, valid1_d;
  logic              multi1_q, multi1_d;

  // Stage 2 registers (decoder results and aligned status)
  logic [WIDTH-1:0]  out_q, out_d;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              multi_q;

  // Priority encoder: highest set bit wins; multi flags a second set bit.
  always_comb begin
    logic seen;
    code1_d  = '0;
    valid1_d = 1'b0;
    multi1_d = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (In[i]) begin
        code1_d  = CODE_W'(i);
        multi1_d = multi1_d | seen;
        seen     = 1'b1;
      end
    end
    valid1_d = seen;
  end

  // Stage 1 capture; asynchronous reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code1_q  <= '0;
      valid1_q <= 1'b0;
      multi1_q <= 1'b0;
    end else begin
      code1_q  <= code1_d;
      valid1_q <= valid1_d;
      multi1_q <= multi1_d;
    end
  end

  // Decoder: one-hot of the code when valid, otherwise all zero.
  always_comb begin
    out_d = '0;
    if (valid1_q) begin
      out_d = WIDTH'(1) << code1_q;
    end
  end

  // Stage 2 capture; status travels with the decoded vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      code_q  <= code1_q;
      valid_q <= valid1_q;
      multi_q <= multi1_q;
    end
  end

  assign Out   = out_q;
  assign Code  = code_q;
  assign Valid = valid_q;
  assign Multi = multi_q;

endmodule

// File: tb/tb_enc_dec.sv
// Bench for enc_dec: directed scenarios plus random and exhaustive stimulus,
// compared against an arithmetic reference model with a two-deep history.
module tb_enc_dec;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CODE_W = 3;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  In;
  logic [WIDTH-1:0]  Out;
  logic [CODE_W-1:0] Code;
  logic              Valid;
  logic              Multi;

  int total = 0;
  int bad   = 0;

  // history of captured inputs: h0 = latest edge, h1 = edge before
  logic [WIDTH-1:0] h0 = '0;
  logic [WIDTH-1:0] h1 = '0;

  enc_dec #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .In    (In),
    .Out   (Out),
    .Code  (Code),
    .Valid (Valid),
    .Multi (Multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: index of top bit via clog2(v+1)-1, flags from popcount
  task automatic check_outputs(input logic [WIDTH-1:0] v);
    int cnt;
    int idx;
    logic [WIDTH-1:0] e_out;
    cnt   = $countones(v);
    idx   = (v == 0) ? 0 : $clog2(int'(v) + 1) - 1;
    e_out = (v == 0) ? '0 : WIDTH'(1 << idx);
    check("out",   32'(Out),   32'(e_out));
    check("code",  32'(Code),  32'(idx));
    check("valid", 32'(Valid), 32'(cnt > 0));
    check("multi", 32'(Multi), 32'(cnt > 1));
    check("inv_onehot", 32'($countones(Out) <= 1), 32'd1);
    check("inv_zero",   32'(Out == 0),             32'(!Valid));
    check("inv_bit",    32'(Out[Code]),            32'(Valid));
  endtask

  // drive v, advance one edge, update history, check outputs #1 later
  task automatic cycle(input logic [WIDTH-1:0] v);
    In = v;
    @(posedge clk);
    if (rst_n) begin
      h1 = h0;
      h0 = v;
    end else begin
      h1 = '0;
      h0 = '0;
    end
    #1;
    check_outputs(h1);
  endtask

  initial begin
    rst_n = 1'b0;
    In    = 8'hFF;

    // reset held with all-ones input and clock running
    repeat (4) cycle(8'hFF);
    check("rst_out", 32'(Out), 32'd0);
    rst_n = 1'b1;
    cycle(8'hFF);
    cycle(8'h00);
    check("rst_rel_out",  32'(Out),   32'h80);
    check("rst_rel_code", 32'(Code),  32'd7);
    check("rst_rel_multi", 32'(Multi), 32'd1);

    // walking one followed by zero
    for (int i = 0; i < 9; i++) cycle(WIDTH'(9'(1) << i));
    cycle(8'h00);
    cycle(8'h00);

    // multi-hot priority, zero vs code 0
    cycle(8'h06);
    cycle(8'hFF);
    cycle(8'h00);
    cycle(8'h01);
    cycle(8'h26);
    cycle(8'h00);
    cycle(8'h00);

    // asynchronous reset between edges with 8'h10 in flight
    cycle(8'h10);
    cycle(8'h10);
    check("pre_async_out", 32'(Out), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out",   32'(Out),   32'd0);
    check("async_valid", 32'(Valid), 32'd0);
    check("async_code",  32'(Code),  32'd0);
    h0 = '0;
    h1 = '0;
    #1;
    rst_n = 1'b1;
    cycle(8'h00);
    cycle(8'h00);
    cycle(8'h00);

    // randomized, biased toward one-hot values
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] r;
      if ($urandom_range(0, 1) == 0) r = WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      else                           r = WIDTH'($urandom);
      cycle(r);
    end

    // exhaustive back-to-back sweep
    for (int v = 0; v < 256; v++) cycle(WIDTH'(v));
    cycle(8'h00);
    cycle(8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // guard against a stuck run
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
